// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU constants and types used by RegisterFile, the CPU top and the
// register-file dump engine.
//   REGISTERS  : number of architectural registers
//   DATA_WIDTH : register width in bits
//   ADDR_WIDTH : register address width (2**ADDR_WIDTH >= REGISTERS)
//   dump_state_t : dump engine FSM states
package cpu_pkg;

  localparam int REGISTERS  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // CHECK is only reachable when the checksum beat is compiled in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump_if
// Bundles the register-file read port and the dump output stream.
//   rd_addr    : address to the register file's combinational read port
//   rd_data    : read data for rd_addr, valid in the same cycle
//   dump_valid : output beat valid
//   dump_ready : consumer accepts the beat
//   dump_index : register index of the beat (REGISTERS = checksum beat)
//   dump_data  : beat payload
//   dump_last  : final beat of the dump
// Modports: master = dump engine, slave = register file / consumer side.
interface regfile_dump_if #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ADDR_WIDTH:0]   dump_index;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output dump_valid,
    input  dump_ready,
    output dump_index,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  dump_valid,
    output dump_ready,
    input  dump_index,
    input  dump_data,
    input  dump_last
  );

endinterface

// File: rtl/regdump_xor_acc.sv
// regdump_xor_acc
// Running XOR of every value loaded into the dump stream; feeds the checksum
// beat of the register-file dump.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the accumulation
//   enable     : fold data into the accumulator
//   data       : value to fold in
//   acc        : current XOR of all folded values
// When clear and enable are both high the result is just data, so the very
// first value of a dump is captured in the same cycle the accumulator clears.
module regdump_xor_acc #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] acc
);

  // Accumulator register: clear drops the old sum, enable XORs the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear || enable) begin
      acc <= (clear ? '0 : acc) ^ (enable ? data : '0);
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump
// Sequential read-out engine for the CPU register file. A start request in
// IDLE walks every architectural register through a dedicated combinational
// read port and streams (index, value) beats on a valid/ready interface.
// The CPU must be halted during a dump since values are sampled live.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, aborts any dump in progress
//   start : level-sampled dump request, only honoured in IDLE
//   busy  : a dump is in progress
//   done  : one-cycle pulse after the final handshake
//   bus   : regfile_dump_if.master (read port + dump stream)
// Optional feature: define REGDUMP_CHECKSUM_EN to append a checksum beat
// (index REGISTERS, payload = XOR of all dumped values) as the last beat.
module regfile_dump #(
  parameter int REGISTERS  = cpu_pkg::REGISTERS,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  regfile_dump_if.master         bus
);

  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH:0] END_CNT = (ADDR_WIDTH + 1)'(REGISTERS);
`ifndef REGDUMP_CHECKSUM_EN
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(REGISTERS - 1);
`endif

  dump_state_t         state;
  logic [ADDR_WIDTH:0] cnt;
  logic                load_en;
  logic                handshake;
  logic                start_dump;

  // The read address comes straight from the counter with no register stage,
  // because the register file answers combinationally in the same cycle.
  assign bus.rd_addr = cnt[ADDR_WIDTH-1:0];

  assign handshake  = bus.dump_valid && bus.dump_ready;
  assign start_dump = (state == IDLE) && start;

  // A new register is loaded whenever the output slot is empty or being
  // drained this cycle, as long as registers remain. A stalled beat therefore
  // never changes under the consumer.
  assign load_en = (state == STREAM) && (!bus.dump_valid || bus.dump_ready) &&
                   (cnt < END_CNT);

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  regdump_xor_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_xor_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_dump),
    .enable (start_dump || load_en),
    .data   (bus.rd_data),
    .acc    (checksum)
  );
`endif

  // Dump FSM with registered outputs. Register 0 is captured on the start
  // edge itself so the first beat is valid right after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_last  <= 1'b0;
      bus.dump_index <= '0;
      bus.dump_data  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bus.dump_data  <= bus.rd_data;
            bus.dump_index <= '0;
            bus.dump_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            bus.dump_last  <= 1'b0;
`else
            bus.dump_last  <= (REGISTERS == 1);
`endif
            busy           <= 1'b1;
            cnt            <= (ADDR_WIDTH + 1)'(1);
            state          <= STREAM;
          end
        end

        STREAM: begin
          if (load_en) begin
            bus.dump_data  <= bus.rd_data;
            bus.dump_index <= cnt;
            bus.dump_valid <= 1'b1;
`ifndef REGDUMP_CHECKSUM_EN
            bus.dump_last  <= (cnt == LAST_IDX);
`endif
            cnt            <= cnt + 1'b1;
          end else if (handshake) begin
            // No registers left and the last register beat was accepted.
`ifdef REGDUMP_CHECKSUM_EN
            bus.dump_index <= END_CNT;
            bus.dump_data  <= checksum;
            bus.dump_last  <= 1'b1;
            state          <= CHECK;
`else
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= FINISH;
`endif
          end
        end

`ifdef REGDUMP_CHECKSUM_EN
        CHECK: begin
          if (handshake) begin
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= FINISH;
          end
        end
`endif

        FINISH: begin
          done  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
// Self-checking bench for regfile_dump. A register array inside the bench
// answers the combinational read port. A behavioural model snapshots the
// register array when a dump is accepted and predicts the exact sequence of
// beats, busy and done; one compare process checks the DUT on every falling
// edge. Directed scenarios plus randomized register contents and ready
// patterns drive the design; a few literal expectations pin the model.
// Honours REGDUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dump;

  import cpu_pkg::*;

  localparam int NREG = REGISTERS;
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ADDR_WIDTH;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int NBEATS = NREG + 1;
`else
  localparam int NBEATS = NREG;
`endif

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  regfile_dump_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_dump #(
    .REGISTERS  (NREG),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  // Register file stand-in with a combinational read port.
  logic [DW-1:0] regs [NREG];
  assign bus.rd_data = regs[bus.rd_addr];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: pending beats of the current dump, plus activity flags.
  int            exp_idx[$];
  logic [DW-1:0] exp_data[$];
  bit            m_active = 1'b0;
  bit            m_finish = 1'b0;

  // Log of accepted beats and busy cycles for the literal checks.
  int            hs_idx[$];
  logic [DW-1:0] hs_data[$];
  int            busy_cycles = 0;
  int            ready_mode  = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // A dump is the register array read in index order, optionally followed
  // by the XOR of all of them at index NREG.
  task automatic load_expected();
    logic [DW-1:0] x;
    x = '0;
    exp_idx.delete();
    exp_data.delete();
    for (int i = 0; i < NREG; i++) begin
      exp_idx.push_back(i);
      exp_data.push_back(regs[i]);
      x ^= regs[i];
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_idx.push_back(NREG);
    exp_data.push_back(x);
`endif
  endtask

  // Compare process: on each falling edge check the outputs against the
  // model, then advance the model to what the next rising edge must do.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 1'b0;
        m_finish = 1'b0;
        exp_idx.delete();
        exp_data.delete();
      end else begin
        check_output("busy", busy, m_active);
        check_output("done", done, m_finish);
        check_output("dump_valid", bus.dump_valid, m_active);
        if (m_active) begin
          check_output("dump_index", bus.dump_index, exp_idx[0]);
          check_output("dump_data", bus.dump_data, exp_data[0]);
          check_output("dump_last", bus.dump_last, exp_idx.size() == 1);
        end
        if (busy) busy_cycles++;
        if (m_finish) begin
          m_finish = 1'b0;
        end else if (m_active) begin
          if (bus.dump_ready) begin
            hs_idx.push_back(int'(bus.dump_index));
            hs_data.push_back(bus.dump_data);
            void'(exp_idx.pop_front());
            void'(exp_data.pop_front());
            if (exp_idx.size() == 0) begin
              m_active = 1'b0;
              m_finish = 1'b1;
            end
          end
        end else if (start) begin
          load_expected();
          m_active = 1'b1;
        end
      end
    end
  end

  // Advance one cycle and drive dump_ready for it according to ready_mode.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.dump_ready = 1'b1;
      1:       bus.dump_ready = ~bus.dump_ready;
      2:       bus.dump_ready = 1'($urandom_range(0, 1));
      default: bus.dump_ready = 1'b0;
    endcase
  endtask

  // Pulse start for one cycle; optionally pin the first beat right away.
  task automatic apply_stimulus(input bit check_latency, input logic [DW-1:0] reg0);
    hs_idx.delete();
    hs_data.delete();
    busy_cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (check_latency) begin
      check_output("latency_valid", bus.dump_valid, 1);
      check_output("latency_index", bus.dump_index, 0);
      check_output("latency_data", bus.dump_data, reg0);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_output("done_within_budget", done, 1);
  endtask

  task automatic wait_index(input int idx, input int budget);
    int n;
    n = 0;
    while (int'(bus.dump_index) != idx && n < budget) begin
      tick();
      n++;
    end
    check_output("reach_index", bus.dump_index, idx);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, bus.dump_valid, 0);
    check_output({tag, "_last"}, bus.dump_last, 0);
    check_output({tag, "_index"}, bus.dump_index, 0);
    check_output({tag, "_data"}, bus.dump_data, 0);
    check_output({tag, "_rd_addr"}, bus.rd_addr, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
  endtask

  task automatic preset_identity();
    for (int i = 0; i < NREG; i++) regs[i] = DW'(i);
  endtask

  // Watchdog: the scenario must never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b1;
    start          = 1'b0;
    bus.dump_ready = 1'b0;
    preset_identity();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Ready tied high: one beat per cycle, register i carries value i.
    $display("[TB] streaming dump with ready high");
    ready_mode = 0;
    tick();
    apply_stimulus(1'b1, '0);
    wait_done(NBEATS + 20);
    check_output("t1_beats", hs_idx.size(), NBEATS);
    check_output("t1_busy_cycles", busy_cycles, NBEATS);
    check_output("t1_idx31", hs_idx[31], 31);
    check_output("t1_data31", hs_data[31], 31);
`ifdef REGDUMP_CHECKSUM_EN
    check_output("t1_chk_idx", hs_idx[32], 32);
    check_output("t1_chk_data", hs_data[32], 32'h0000_0000);
`endif

    // Ready toggling: every beat held while stalled, no skips or repeats.
    $display("[TB] streaming dump with ready toggling");
    ready_mode = 1;
    tick();
    apply_stimulus(1'b0, '0);
    wait_done(4 * NBEATS + 20);
    check_output("t2_beats", hs_idx.size(), NBEATS);
    for (int k = 0; k < NREG; k++) begin
      check_output("t2_order_idx", hs_idx[k], k);
      check_output("t2_order_data", hs_data[k], k);
    end

    // One register with high bits set.
    $display("[TB] dump with register 5 = 0xFFFF0000");
    regs[5]    = 32'hFFFF_0000;
    ready_mode = 0;
    tick();
    apply_stimulus(1'b0, '0);
    wait_done(NBEATS + 20);
    check_output("t3_reg5", hs_data[5], 32'hFFFF_0000);
`ifdef REGDUMP_CHECKSUM_EN
    check_output("t3_checksum", hs_data[32], 32'hFFFF_0005);
`endif
    regs[5] = 32'd5;

    // A second start in the middle of a dump is ignored.
    $display("[TB] start pulse during beat 10");
    tick();
    apply_stimulus(1'b0, '0);
    wait_index(10, 40);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(NBEATS + 20);
    check_output("t4_beats", hs_idx.size(), NBEATS);
    check_output("t4_last_idx", hs_idx[NREG-1], NREG - 1);
    tick();
    tick();
    check_output("t4_no_restart", busy, 0);

    // Randomized register contents and ready patterns.
    $display("[TB] randomized dumps");
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < NREG; i++) regs[i] = DW'($urandom);
      ready_mode = 2;
      tick();
      apply_stimulus(1'b0, '0);
      wait_done(10 * NBEATS + 50);
      check_output("rand_beats", hs_idx.size(), NBEATS);
    end
    preset_identity();

    // Reset while the beat at index 17 is stalled.
    $display("[TB] reset during stalled beat 17");
    ready_mode = 0;
    tick();
    apply_stimulus(1'b1, '0);
    wait_index(17, 40);
    ready_mode     = 3;
    bus.dump_ready = 1'b0;
    tick();
    tick();
    check_output("t6_stalled_idx", bus.dump_index, 17);
    check_output("t6_stalled_data", bus.dump_data, 17);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n      = 1'b1;
    ready_mode = 0;
    tick();
    apply_stimulus(1'b1, '0);
    wait_done(NBEATS + 20);
    check_output("t6_beats", hs_idx.size(), NBEATS);
    check_output("t6_first_idx", hs_idx[0], 0);

    // Start held high: back-to-back dumps with one FINISH and one IDLE cycle.
    $display("[TB] back-to-back dumps with start held");
    tick();
    start = 1'b1;
    tick();
    wait_done(NBEATS + 20);
    tick();
    check_output("t7_gap_busy", busy, 0);
    check_output("t7_gap_valid", bus.dump_valid, 0);
    tick();
    check_output("t7_restart_busy", busy, 1);
    check_output("t7_restart_index", bus.dump_index, 0);
    start = 1'b0;
    wait_done(NBEATS + 20);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
